muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk_87 and rst_87.
REQ-002 The block SHALL have parameter W, default `DATA_WIDTH (32), which sets the operand and HI/LO width.
REQ-003 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_87  in  1  clock, rising edge.
- rst_87  in  1  asynchronous active-high reset.
- start_87  in  1  EX stage issues a MULT/MULTU/DIV/DIVU.
- md_op_87  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- arg_a_87  in  W  rs value.
- arg_b_87  in  W  rt value.
- hilo_rd_87  in  1  EX stage issues an MFHI/MFLO.
- flush_87  in  1  pipeline flush; aborts the operation in flight.
- hi_87  out  W  HI register.
- lo_87  out  W  LO register.
- busy_87  out  1  high when state is PREP, CALC or FIXUP.
- done_87  out  1  one-cycle pulse; HI/LO just updated.
- div_zero_87  out  1  pulses together with done_87 when the divisor was 0.
- stall_87  out  1  combinational; holds the IF, ID and EX stages.

Function
REQ-004 The FSM SHALL have states IDLE, PREP, CALC, FIXUP and DONE.
REQ-005 start_87 SHALL be accepted only in IDLE or DONE; on acceptance the block latches op, the operand magnitudes and the operand signs, and moves to PREP.
REQ-006 PREP SHALL last 1 cycle, then:
- divide with arg_b_87 == 0 -> DONE;
- otherwise -> CALC.
REQ-007 CALC SHALL run exactly W cycles; an internal counter counts 0..W-1 and then the FSM moves to FIXUP.
REQ-008 FIXUP SHALL last 1 cycle, apply the sign correction and load HI/LO; the FSM then moves to DONE.
REQ-009 DONE SHALL last 1 cycle with done_87=1, then return to IDLE unless a new start is accepted in that cycle.
REQ-010 Latency SHALL be: done_87 high in the cycle after the (W+3)th rising edge counted from the accepting edge (35 edges for W=32); divide-by-zero SHALL give done_87 2 edges after the accepting edge.
REQ-011 Multiply SHALL be radix-2 shift-add producing a 2W-bit product: hi_87 = product[2W-1:W], lo_87 = product[W-1:0].
REQ-012 MULT SHALL negate the product when the operand signs differ; MULTU SHALL treat both operands as unsigned.
REQ-013 Divide SHALL be restoring, one quotient bit per CALC cycle: lo_87 = quotient, hi_87 = remainder.
REQ-014 DIV SHALL give the quotient sign = sign(a) XOR sign(b) and the remainder sign = sign(a); results wrap modulo 2^W, so 0x80000000 / -1 gives lo=0x80000000, hi=0.
REQ-015 Divide-by-zero SHALL set hi_87 = arg_a, lo_87 = all ones, div_zero_87 = 1 for the DONE cycle.
REQ-016 stall_87 SHALL equal (start_87 OR hilo_rd_87) AND busy_87.
REQ-017 A start_87 received while busy SHALL be held off by stall_87 and accepted in DONE.
REQ-018 hi_87 and lo_87 SHALL change only at the edge entering DONE and SHALL be stable at all other times.
REQ-019 flush_87 while busy SHALL return the FSM to IDLE at the next edge with no done_87 pulse and HI/LO unchanged.
REQ-020 flush_87 together with start_87 SHALL leave start_87 ignored (flush wins).
REQ-021 Operand changes after acceptance SHALL have no effect on the result.

Reset
REQ-022 rst_87 SHALL immediately, without waiting for a clock edge, force state=IDLE, counter=0, hi_87=0, lo_87=0, done_87=0, div_zero_87=0 and busy_87=0, including mid-CALC.
REQ-023 The first start_87 SHALL be accepted at the first rising edge after rst_87 deasserts.

Structure
REQ-024 The md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) SHALL be defined in mips_defs.vh; the state encodings SHALL be local to the module.
REQ-025 The block SHALL contain exactly one sub-module, md_step: a combinational single-iteration shift/add-subtract of a (2W+1)-bit working register, selected by multiply/divide.

Verification
REQ-026 MULT a=7, b=0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done_87 35 edges after start, busy_87 high for 34 cycles.
REQ-027 MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 -> lo=14, hi=2.
REQ-028 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-029 DIV a=5, b=0 -> done_87 and div_zero_87 2 edges after start, hi=5, lo=0xFFFFFFFF.
REQ-030 Back-to-back and read hazard: start op1, then hold start_87 and hilo_rd_87 high -> stall_87=1 until DONE, op2 accepted in DONE, second result correct.
REQ-031 Flush and reset mid-operation:
- flush_87 at CALC cycle 10 -> IDLE next edge, no done_87, HI/LO keep the prior values;
- rst_87 pulsed mid-CALC -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/muldiv_seq_pkg.sv
// Operation decode helpers shared by the sequential multiply/divide unit.
`include "mips_defs.vh"

package muldiv_seq_pkg;

    typedef logic [1:0] md_op_t;

    function automatic logic op_is_div(input md_op_t op);
        return (op == `MD_DIV) || (op == `MD_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_t op);
        return (op == `MD_MULT) || (op == `MD_DIV);
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of radix-2 shift-add multiply or restoring divide on a
// (2W+1)-bit working register {upper W+1 bits, lower W bits}.
module md_step #(
    parameter int W = 32
) (
    input  logic           is_div,
    input  logic [2*W:0]   acc,
    input  logic [W-1:0]   operand,
    output logic [2*W:0]   acc_next
);

    logic [W:0]   mul_sum;
    logic [W:0]   rem_shift;
    logic [W+1:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole register right.
        mul_sum   = acc[2*W:W] + (acc[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the partial remainder.
        rem_shift = acc[2*W-1:W-1];
        diff      = {1'b0, rem_shift} - {2'b00, operand};
        if (is_div) begin
            if (diff[W+1])
                acc_next = {rem_shift, acc[W-2:0], 1'b0};
            else
                acc_next = {diff[W:0], acc[W-2:0], 1'b1};
        end else begin
            acc_next = {1'b0, mul_sum, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/mips_defs.vh
// Shared MIPS core definitions: datapath width and HI/LO unit operation codes.
`ifndef MIPS_DEFS_VH
`define MIPS_DEFS_VH

`define DATA_WIDTH 32

`define MD_MULT  2'b00
`define MD_MULTU 2'b01
`define MD_DIV   2'b10
`define MD_DIVU  2'b11

`endif

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers and pipeline stall.
`include "mips_defs.vh"

module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int W = `DATA_WIDTH
) (
    input  logic         clk_87,
    input  logic         rst_87,
    input  logic         start_87,
    input  logic [1:0]   md_op_87,
    input  logic [W-1:0] arg_a_87,
    input  logic [W-1:0] arg_b_87,
    input  logic         hilo_rd_87,
    input  logic         flush_87,
    output logic [W-1:0] hi_87,
    output logic [W-1:0] lo_87,
    output logic         busy_87,
    output logic         done_87,
    output logic         div_zero_87,
    output logic         stall_87
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg;
    md_op_t         op_reg;
    logic           sign_a_reg, sign_b_reg;
    logic [W-1:0]   mag_a_reg, mag_b_reg;
    logic [2*W:0]   acc_reg, acc_step;
    logic [W-1:0]   hi_reg, lo_reg;
    logic           dz_reg;

    logic           accept;
    logic           signed_in, sign_a_in, sign_b_in;
    logic [W-1:0]   mag_a_in, mag_b_in;
    logic           is_div_w, signed_w, b_zero;
    logic [W-1:0]   step_operand;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, hi_fix, lo_fix, a_orig;
    logic           load_result, load_dz;

    // Operand capture: signed ops store magnitude and sign separately.
    always_comb begin
        accept    = start_87 && !flush_87 && (state_reg == S_IDLE || state_reg == S_DONE);
        signed_in = op_is_signed(md_op_87);
        sign_a_in = signed_in & arg_a_87[W-1];
        sign_b_in = signed_in & arg_b_87[W-1];
        mag_a_in  = sign_a_in ? -arg_a_87 : arg_a_87;
        mag_b_in  = sign_b_in ? -arg_b_87 : arg_b_87;
    end

    always_comb begin
        is_div_w     = op_is_div(op_reg);
        signed_w     = op_is_signed(op_reg);
        b_zero       = (mag_b_reg == '0);
        step_operand = is_div_w ? mag_b_reg : mag_a_reg;
    end

    md_step #(.W(W)) u_step (
        .is_div   (is_div_w),
        .acc      (acc_reg),
        .operand  (step_operand),
        .acc_next (acc_step)
    );

    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_PREP;
            S_PREP: begin
                if (flush_87)                state_next = S_IDLE;
                else if (is_div_w && b_zero) state_next = S_DONE;
                else                         state_next = S_CALC;
            end
            S_CALC: begin
                if (flush_87)                     state_next = S_IDLE;
                else if (cnt_reg == CW'(W - 1))   state_next = S_FIXUP;
            end
            S_FIXUP: state_next = flush_87 ? S_IDLE : S_DONE;
            S_DONE:  state_next = accept ? S_PREP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Sign correction of the unsigned magnitude result.
    always_comb begin
        prod = acc_reg[2*W-1:0];
        if (signed_w && !is_div_w && (sign_a_reg ^ sign_b_reg))
            prod = -acc_reg[2*W-1:0];
        quo = acc_reg[W-1:0];
        if (signed_w && (sign_a_reg ^ sign_b_reg))
            quo = -acc_reg[W-1:0];
        rem = acc_reg[2*W-1:W];
        if (signed_w && sign_a_reg)
            rem = -acc_reg[2*W-1:W];
        hi_fix      = is_div_w ? rem : prod[2*W-1:W];
        lo_fix      = is_div_w ? quo : prod[W-1:0];
        a_orig      = sign_a_reg ? -mag_a_reg : mag_a_reg;
        load_result = (state_reg == S_FIXUP) && (state_next == S_DONE);
        load_dz     = (state_reg == S_PREP) && (state_next == S_DONE);
    end

    always_ff @(posedge clk_87 or posedge rst_87) begin
        if (rst_87) begin
            cnt_reg    <= '0;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            acc_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dz_reg     <= 1'b0;
        end else begin
            cnt_reg <= (state_reg == S_CALC && state_next == S_CALC) ? cnt_reg + 1'b1 : '0;
            if (accept) begin
                op_reg     <= md_op_87;
                sign_a_reg <= sign_a_in;
                sign_b_reg <= sign_b_in;
                mag_a_reg  <= mag_a_in;
                mag_b_reg  <= mag_b_in;
                // Low half holds the multiplier or the dividend.
                acc_reg    <= {{(W+1){1'b0}}, op_is_div(md_op_87) ? mag_a_in : mag_b_in};
            end else if (state_reg == S_CALC) begin
                acc_reg <= acc_step;
            end
            if (load_result) begin
                hi_reg <= hi_fix;
                lo_reg <= lo_fix;
                dz_reg <= 1'b0;
            end else if (load_dz) begin
                hi_reg <= a_orig;
                lo_reg <= '1;
                dz_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        hi_87       = hi_reg;
        lo_87       = lo_reg;
        busy_87     = (state_reg == S_PREP) || (state_reg == S_CALC) || (state_reg == S_FIXUP);
        done_87     = (state_reg == S_DONE);
        div_zero_87 = done_87 && dz_reg;
        stall_87    = (start_87 || hilo_rd_87) && busy_87;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vectors, random ops against an
// arithmetic reference, back-to-back hazard, flush and asynchronous reset.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk_87 = 1'b0;
    logic         rst_87 = 1'b0;
    logic         start_87 = 1'b0;
    logic [1:0]   md_op_87 = 2'b00;
    logic [W-1:0] arg_a_87 = '0;
    logic [W-1:0] arg_b_87 = '0;
    logic         hilo_rd_87 = 1'b0;
    logic         flush_87 = 1'b0;
    logic [W-1:0] hi_87, lo_87;
    logic         busy_87, done_87, div_zero_87, stall_87;

    int total = 0;
    int bad   = 0;

    always #5 clk_87 = ~clk_87;

    muldiv_seq #(.W(W)) dut (
        .clk_87      (clk_87),
        .rst_87      (rst_87),
        .start_87    (start_87),
        .md_op_87    (md_op_87),
        .arg_a_87    (arg_a_87),
        .arg_b_87    (arg_b_87),
        .hilo_rd_87  (hilo_rd_87),
        .flush_87    (flush_87),
        .hi_87       (hi_87),
        .lo_87       (lo_87),
        .busy_87     (busy_87),
        .done_87     (done_87),
        .div_zero_87 (div_zero_87),
        .stall_87    (stall_87)
    );

    // Reference: MIPS HI/LO semantics with 64-bit arithmetic, returns {hi, lo}.
    function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Issue one operation from a negedge and wait for done (bounded).
    // edges = rising edges from the accepting one up to the done cycle, -1 on timeout.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int edges,
                         output int busy_cycles, output logic dz, output bit early);
        logic [31:0] hi0, lo0;
        bit seen;
        hi0 = hi_87;
        lo0 = lo_87;
        start_87 = 1'b1;
        md_op_87 = op;
        arg_a_87 = a;
        arg_b_87 = b;
        @(posedge clk_87);
        edges = 1;
        busy_cycles = 0;
        early = 1'b0;
        seen = 1'b0;
        @(negedge clk_87);
        start_87 = 1'b0;
        arg_a_87 = $urandom;
        arg_b_87 = $urandom;
        md_op_87 = 2'($urandom_range(0, 3));
        for (int i = 0; i < 100; i++) begin
            if (done_87) begin
                seen = 1'b1;
                break;
            end
            if (busy_87) busy_cycles++;
            if (hi_87 !== hi0 || lo_87 !== lo0) early = 1'b1;
            @(posedge clk_87);
            edges++;
            @(negedge clk_87);
        end
        if (!seen) edges = -1;
        hi = hi_87;
        lo = lo_87;
        dz = div_zero_87;
        $display("op=%0d a=%h b=%h hi=%h lo=%h dz=%0b edges=%0d", op, a, b, hi, lo, dz, edges);
    endtask

    task automatic test_reset();
        #1 rst_87 = 1'b1;
        #1;
        total++;
        if ({hi_87, lo_87} !== 64'h0) begin
            bad++;
            $display("FAIL reset_hilo got=%h want=0", {hi_87, lo_87});
        end
        total++;
        if ({busy_87, done_87, div_zero_87, stall_87} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000", {busy_87, done_87, div_zero_87, stall_87});
        end
        repeat (2) @(negedge clk_87);
        rst_87 = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        int          edges;
        logic        dz;
    } vec_t;

    task automatic test_directed();
        vec_t v[7];
        logic [31:0] hi, lo;
        int edges, bc;
        logic dz;
        bit early;
        v[0] = '{2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 35, 1'b0};
        v[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 35, 1'b0};
        v[2] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 35, 1'b0};
        v[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35, 1'b0};
        v[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 35, 1'b0};
        v[5] = '{2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 1'b1};
        v[6] = '{2'b11, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, hi, lo, edges, bc, dz, early);
            total++;
            if ({hi, lo} !== {v[i].hi, v[i].lo}) begin
                bad++;
                $display("FAIL directed_%0d_result got=%h_%h want=%h_%h", i, hi, lo, v[i].hi, v[i].lo);
            end
            total++;
            if (edges != v[i].edges) begin
                bad++;
                $display("FAIL directed_%0d_latency got=%0d want=%0d", i, edges, v[i].edges);
            end
            total++;
            if (dz !== v[i].dz) begin
                bad++;
                $display("FAIL directed_%0d_divzero got=%b want=%b", i, dz, v[i].dz);
            end
            total++;
            if (early) begin
                bad++;
                $display("FAIL directed_%0d_hilo_stable got=changed want=stable", i);
            end
            if (i == 0) begin
                total++;
                if (bc != 34) begin
                    bad++;
                    $display("FAIL directed_busy_cycles got=%0d want=34", bc);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic [63:0] exp;
        int edges, bc;
        logic dz;
        bit early;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            exp = ref_md(op, a, b);
            do_op(op, a, b, hi, lo, edges, bc, dz, early);
            total++;
            if ({hi, lo} !== exp) begin
                bad++;
                $display("FAIL random_%0d_result op=%0d got=%h_%h want=%h", i, op, hi, lo, exp);
            end
            total++;
            if (edges != ((op[1] && b == 0) ? 2 : W + 3)) begin
                bad++;
                $display("FAIL random_%0d_latency got=%0d", i, edges);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] exp1, exp2;
        int stall_bad, edges;
        bit seen;
        a1 = $urandom; b1 = $urandom;
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        exp1 = ref_md(2'b00, a1, b1);
        exp2 = ref_md(2'b10, a2, b2);
        start_87 = 1'b1; md_op_87 = 2'b00; arg_a_87 = a1; arg_b_87 = b1;
        @(posedge clk_87);
        @(negedge clk_87);
        md_op_87 = 2'b10; arg_a_87 = a2; arg_b_87 = b2; hilo_rd_87 = 1'b1;
        stall_bad = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_87) begin
                seen = 1'b1;
                break;
            end
            if (stall_87 !== 1'b1) stall_bad++;
            @(negedge clk_87);
        end
        total++;
        if (!seen || stall_bad != 0) begin
            bad++;
            $display("FAIL b2b_stall seen_done=%0b stall_low_cycles=%0d want=1,0", seen, stall_bad);
        end
        total++;
        if (stall_87 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stall_in_done got=%b want=0", stall_87);
        end
        total++;
        if ({hi_87, lo_87} !== exp1) begin
            bad++;
            $display("FAIL b2b_first got=%h_%h want=%h", hi_87, lo_87, exp1);
        end
        $display("op=0 a=%h b=%h hi=%h lo=%h (first of pair)", a1, b1, hi_87, lo_87);
        @(posedge clk_87);
        edges = 1;
        @(negedge clk_87);
        start_87 = 1'b0; hilo_rd_87 = 1'b0;
        arg_a_87 = $urandom; arg_b_87 = $urandom;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_87) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk_87);
            edges++;
            @(negedge clk_87);
        end
        total++;
        if (!seen || edges != W + 3 || {hi_87, lo_87} !== exp2) begin
            bad++;
            $display("FAIL b2b_second got=%h_%h edges=%0d want=%h edges=%0d", hi_87, lo_87, edges, exp2, W + 3);
        end
        $display("op=2 a=%h b=%h hi=%h lo=%h edges=%0d (second of pair)", a2, b2, hi_87, lo_87, edges);
    endtask

    task automatic test_flush();
        logic [31:0] hi, lo, hi0, lo0;
        int edges, bc, dones;
        logic dz;
        bit early;
        do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, hi, lo, edges, bc, dz, early);
        @(negedge clk_87);
        hi0 = hi_87;
        lo0 = lo_87;
        start_87 = 1'b1; md_op_87 = 2'b00; arg_a_87 = $urandom; arg_b_87 = $urandom;
        @(posedge clk_87);
        @(negedge clk_87);
        start_87 = 1'b0;
        repeat (11) @(negedge clk_87);
        flush_87 = 1'b1;
        @(negedge clk_87);
        flush_87 = 1'b0;
        total++;
        if (busy_87 !== 1'b0 || done_87 !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle busy=%b done=%b want=0,0", busy_87, done_87);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_87) dones++;
            @(negedge clk_87);
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL flush_no_done got=%0d pulses want=0", dones);
        end
        total++;
        if (hi_87 !== hi0 || lo_87 !== lo0) begin
            bad++;
            $display("FAIL flush_hilo got=%h_%h want=%h_%h", hi_87, lo_87, hi0, lo0);
        end
        $display("flush mid-calc hi=%h lo=%h", hi_87, lo_87);
        start_87 = 1'b1; flush_87 = 1'b1;
        @(negedge clk_87);
        start_87 = 1'b0; flush_87 = 1'b0;
        total++;
        if (busy_87 !== 1'b0) begin
            bad++;
            $display("FAIL flush_beats_start busy got=%b want=0", busy_87);
        end
        $display("flush with start busy=%b", busy_87);
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo;
        int edges, bc;
        logic dz;
        bit early;
        start_87 = 1'b1; md_op_87 = 2'b11; arg_a_87 = $urandom; arg_b_87 = 32'd3;
        @(posedge clk_87);
        @(negedge clk_87);
        start_87 = 1'b0;
        repeat (15) @(negedge clk_87);
        #2 rst_87 = 1'b1;
        #1;
        total++;
        if ({hi_87, lo_87} !== 64'h0 || {busy_87, done_87, div_zero_87} !== 3'b0) begin
            bad++;
            $display("FAIL reset_mid got=%h_%h flags=%b want=0", hi_87, lo_87, {busy_87, done_87, div_zero_87});
        end
        $display("reset mid-calc hi=%h lo=%h busy=%b", hi_87, lo_87, busy_87);
        @(negedge clk_87);
        rst_87 = 1'b0;
        do_op(2'b10, 32'hFFFF_FF9C, 32'd7, hi, lo, edges, bc, dz, early);
        total++;
        if ({hi, lo} !== ref_md(2'b10, 32'hFFFF_FF9C, 32'd7) || edges != W + 3) begin
            bad++;
            $display("FAIL reset_first_start got=%h_%h edges=%0d want=%h edges=%0d",
                     hi, lo, edges, ref_md(2'b10, 32'hFFFF_FF9C, 32'd7), W + 3);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
